// File: rtl/result_wb_pkg.sv
// Shared types, default parameters and data conversion helper for the result
// write-back unit. Optional checksum feature: RESULT_WB_CHECKSUM_EN.
package result_wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2
    } wb_state_t;

    localparam int DEF_N         = 4;
    localparam int DEF_ACCW      = 16;
    localparam int DEF_DW        = 16;
    localparam int DEF_ADDRW     = 9;
    localparam int DEF_BASE_ADDR = 0;

    localparam int SAT_W = 64;

    // Unsigned saturation to dw bits; values already in range pass unchanged.
    function automatic logic [SAT_W-1:0] sat_trunc(input logic [SAT_W-1:0] value, input int dw);
        logic [SAT_W-1:0] max_val;
        max_val = (dw >= SAT_W) ? '1 : ((SAT_W'(1) << dw) - SAT_W'(1));
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/result_wb_edge_det.sv
// Rising-edge detector: one-cycle pulse when din is high and was low on the
// previous clock edge. Asynchronous active-high reset clears the history.
module result_wb_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    assign prev_d = din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= prev_d;
    end

    assign rise = din & ~prev_q;

endmodule

// File: rtl/result_bram_writer.sv
// Snapshots the flat N x N result on a rising start and streams it row-major
// into a BRAM write port. Define RESULT_WB_CHECKSUM_EN to add a checksum output.
module result_bram_writer
    import result_wb_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int ACCW      = DEF_ACCW,
    parameter int DW        = DEF_DW,
    parameter int ADDRW     = DEF_ADDRW,
    parameter int BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ACCW*N*N-1:0]  C_flat,
    output logic                 bram_en,
    output logic                 bram_we,
    output logic [ADDRW-1:0]     bram_addr,
    output logic [DW-1:0]        bram_din,
    output logic                 busy,
    output logic                 wr_done
`ifdef RESULT_WB_CHECKSUM_EN
    ,
    output logic [31:0]          checksum
`endif
);

    localparam int NUM = N * N;
    localparam int KW  = (NUM > 1) ? $clog2(NUM) : 1;

    wb_state_t            state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [ACCW*NUM-1:0]  shadow_q, shadow_d;
    logic                 en_q, en_d;
    logic [ADDRW-1:0]     addr_q, addr_d;
    logic [DW-1:0]        din_q, din_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [ACCW-1:0]      elem;
    logic                 rise;
`ifdef RESULT_WB_CHECKSUM_EN
    logic [31:0]          csum_q, csum_d;
`endif

    result_wb_edge_det u_edge (
        .clk  (clk),
        .rst  (reset),
        .din  (start),
        .rise (rise)
    );

    assign elem = shadow_q[int'(k_q) * ACCW +: ACCW];

    // NOTE: next-state logic is purely combinational with every target given a
    // default first, so no latches; only the always_ff below holds state.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        shadow_d = shadow_q;
        en_d     = 1'b0;
        addr_d   = '0;
        din_d    = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef RESULT_WB_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (rise) begin
                    shadow_d = C_flat;
                    k_d      = '0;
                    state_d  = WRITE;
`ifdef RESULT_WB_CHECKSUM_EN
                    csum_d   = '0;
`endif
                end
            end
            WRITE: begin
                en_d   = 1'b1;
                busy_d = 1'b1;
                addr_d = ADDRW'(BASE_ADDR) + ADDRW'(k_q);
                din_d  = DW'(sat_trunc(SAT_W'(elem), DW));
                k_d    = k_q + 1'b1;
`ifdef RESULT_WB_CHECKSUM_EN
                csum_d = csum_q + 32'(din_d);
`endif
                if (k_q == KW'(NUM - 1)) state_d = FINISH;
            end
            FINISH: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            shadow_q <= '0;
            en_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef RESULT_WB_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            shadow_q <= shadow_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef RESULT_WB_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign bram_en   = en_q;
    assign bram_we   = en_q;
    assign bram_addr = addr_q;
    assign bram_din  = din_q;
    assign busy      = busy_q;
    assign wr_done   = done_q;
`ifdef RESULT_WB_CHECKSUM_EN
    assign checksum  = csum_q;
`endif

endmodule

// File: tb/tb_result_bram_writer.sv
// Self-checking bench for result_bram_writer: three instances (default,
// DW=8 saturation, BASE_ADDR=510 wrap) checked against an array-based model.
module tb_result_bram_writer;

    localparam int NUM = 16;

    logic clk = 1'b0;
    logic reset;
    logic a_start, b_start, c_start;
    logic [255:0] a_c, b_c, c_c;

    logic a_en, a_we, a_busy, a_done;
    logic [8:0] a_addr;
    logic [15:0] a_din;
    logic b_en, b_we, b_busy, b_done;
    logic [8:0] b_addr;
    logic [7:0] b_din;
    logic c_en, c_we, c_busy, c_done;
    logic [8:0] c_addr;
    logic [15:0] c_din;
`ifdef RESULT_WB_CHECKSUM_EN
    logic [31:0] a_checksum, b_checksum, c_checksum;
`endif

    int checks = 0;
    int failures = 0;
    int mat[NUM];
    int exp_addr[NUM];
    int exp_din[NUM];

    logic s_en, s_we, s_busy, s_done;
    logic [31:0] s_addr, s_din;

    always #5 clk = ~clk;

    result_bram_writer dut_a (
        .clk(clk), .reset(reset), .start(a_start), .C_flat(a_c),
        .bram_en(a_en), .bram_we(a_we), .bram_addr(a_addr), .bram_din(a_din),
        .busy(a_busy), .wr_done(a_done)
`ifdef RESULT_WB_CHECKSUM_EN
        , .checksum(a_checksum)
`endif
    );

    result_bram_writer #(.DW(8)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .C_flat(b_c),
        .bram_en(b_en), .bram_we(b_we), .bram_addr(b_addr), .bram_din(b_din),
        .busy(b_busy), .wr_done(b_done)
`ifdef RESULT_WB_CHECKSUM_EN
        , .checksum(b_checksum)
`endif
    );

    result_bram_writer #(.BASE_ADDR(510)) dut_c (
        .clk(clk), .reset(reset), .start(c_start), .C_flat(c_c),
        .bram_en(c_en), .bram_we(c_we), .bram_addr(c_addr), .bram_din(c_din),
        .busy(c_busy), .wr_done(c_done)
`ifdef RESULT_WB_CHECKSUM_EN
        , .checksum(c_checksum)
`endif
    );

    function automatic logic [255:0] pack_mat();
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < NUM; k++) v[k*16 +: 16] = 16'(mat[k]);
        return v;
    endfunction

    // Reference model: row-major order, address modulo 512, unsigned clamp to dw bits.
    task automatic build_expect(input int base, input int dw);
        int max_v;
        max_v = (1 << dw) - 1;
        for (int k = 0; k < NUM; k++) begin
            exp_addr[k] = (base + k) % 512;
            exp_din[k]  = (mat[k] > max_v) ? max_v : mat[k];
        end
    endtask

    task automatic sample(input int sel);
        case (sel)
            0: begin s_en = a_en; s_we = a_we; s_addr = 32'(a_addr); s_din = 32'(a_din);
                     s_busy = a_busy; s_done = a_done; end
            1: begin s_en = b_en; s_we = b_we; s_addr = 32'(b_addr); s_din = 32'(b_din);
                     s_busy = b_busy; s_done = b_done; end
            default: begin s_en = c_en; s_we = c_we; s_addr = 32'(c_addr); s_din = 32'(c_din);
                     s_busy = c_busy; s_done = c_done; end
        endcase
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0: a_start = v;
            1: b_start = v;
            default: c_start = v;
        endcase
    endtask

    task automatic set_c(input int sel, input logic [255:0] v);
        case (sel)
            0: a_c = v;
            1: b_c = v;
            default: c_c = v;
        endcase
    endtask

    function automatic logic [255:0] rand_bus();
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // Called at a negedge with start already presented; the next posedge is edge T.
    task automatic expect_burst(input int sel, input string name, input bit scramble);
        int sum;
        logic exp_busy, exp_done;
        sum = 0;
        for (int j = 0; j <= NUM + 2; j++) begin
            @(negedge clk);
            sample(sel);
            if (j >= 1 && j <= NUM) begin
                checks++;
                if (s_en !== 1'b1 || s_we !== 1'b1) begin
                    failures++;
                    $display("FAIL %s cyc%0d en/we got %b/%b want 1/1", name, j, s_en, s_we);
                end
                checks++;
                if (s_addr !== 32'(exp_addr[j-1])) begin
                    failures++;
                    $display("FAIL %s cyc%0d addr got %0d want %0d", name, j, s_addr, exp_addr[j-1]);
                end
                checks++;
                if (s_din !== 32'(exp_din[j-1])) begin
                    failures++;
                    $display("FAIL %s cyc%0d din got %0d want %0d", name, j, s_din, exp_din[j-1]);
                end
                sum += exp_din[j-1];
            end else begin
                checks++;
                if (s_en !== 1'b0 || s_we !== 1'b0) begin
                    failures++;
                    $display("FAIL %s cyc%0d idle en/we got %b/%b want 0/0", name, j, s_en, s_we);
                end
            end
            exp_busy = (j >= 1 && j <= NUM + 1);
            exp_done = (j == NUM + 1);
            checks++;
            if (s_busy !== exp_busy) begin
                failures++;
                $display("FAIL %s cyc%0d busy got %b want %b", name, j, s_busy, exp_busy);
            end
            checks++;
            if (s_done !== exp_done) begin
                failures++;
                $display("FAIL %s cyc%0d wr_done got %b want %b", name, j, s_done, exp_done);
            end
`ifdef RESULT_WB_CHECKSUM_EN
            if (sel == 0 && j == NUM + 1) begin
                checks++;
                if (a_checksum !== 32'(sum)) begin
                    failures++;
                    $display("FAIL %s checksum got %0d want %0d", name, a_checksum, sum);
                end
            end
`endif
            if (scramble && j == 3) set_c(sel, rand_bus());
        end
        set_start(sel, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input int sel, input string name);
        sample(sel);
        checks++;
        if ({s_en, s_we, s_busy, s_done} !== 4'b0 || s_addr !== 32'd0 || s_din !== 32'd0) begin
            failures++;
            $display("FAIL %s en/we/busy/done=%b%b%b%b addr=%0d din=%0d want all 0",
                     name, s_en, s_we, s_busy, s_done, s_addr, s_din);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_c = '0; b_c = '0; c_c = '0;
        repeat (3) @(negedge clk);
        check_zero(0, "reset_a");
        check_zero(1, "reset_b");
        check_zero(2, "reset_c");
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        for (int k = 0; k < NUM; k++) mat[k] = k + 1;
        a_c = pack_mat();
        build_expect(0, 16);
        a_start = 1'b1;
        expect_burst(0, "basic", 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NUM; k++) mat[k] = int'($urandom_range(0, 65535));
            a_c = pack_mat();
            build_expect(0, 16);
            a_start = 1'b1;
            expect_burst(0, "random_shadow", 1'b1);
        end
    endtask

    task automatic test_held_start();
        int en_cnt, done_cnt;
        en_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < NUM; k++) mat[k] = int'($urandom_range(0, 65535));
        a_c = pack_mat();
        a_start = 1'b1;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (a_en === 1'b1) en_cnt++;
            if (a_done === 1'b1) done_cnt++;
        end
        checks++;
        if (en_cnt != NUM) begin
            failures++;
            $display("FAIL held_start writes got %0d want %0d", en_cnt, NUM);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL held_start wr_done pulses got %0d want 1", done_cnt);
        end
        a_start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NUM; k++) mat[k] = 7;
        a_c = pack_mat();
        build_expect(0, 16);
        a_start = 1'b1;
        expect_burst(0, "restart_sevens", 1'b0);
    endtask

    task automatic test_saturate();
        for (int k = 0; k < NUM; k++) mat[k] = int'($urandom_range(0, 65535));
        mat[0] = 300;
        mat[1] = 255;
        mat[2] = 12;
        mat[3] = 256;
        b_c = pack_mat();
        build_expect(0, 8);
        b_start = 1'b1;
        expect_burst(1, "saturate_dw8", 1'b0);
    endtask

    task automatic test_wrap();
        for (int k = 0; k < NUM; k++) mat[k] = int'($urandom_range(0, 65535));
        c_c = pack_mat();
        build_expect(510, 16);
        c_start = 1'b1;
        expect_burst(2, "addr_wrap", 1'b0);
    endtask

    task automatic test_mid_reset();
        int en_cnt;
        for (int k = 0; k < NUM; k++) mat[k] = k + 1;
        a_c = pack_mat();
        build_expect(0, 16);
        a_start = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (a_en !== 1'b1 || a_addr !== 9'(exp_addr[4])) begin
            failures++;
            $display("FAIL mid_reset fifth write en=%b addr=%0d want 1/%0d", a_en, a_addr, exp_addr[4]);
        end
        #2 reset = 1'b1;
        #1 check_zero(0, "mid_reset_async");
        @(negedge clk);
        a_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        en_cnt = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (a_en === 1'b1 || a_done === 1'b1 || a_busy === 1'b1) en_cnt++;
        end
        checks++;
        if (en_cnt != 0) begin
            failures++;
            $display("FAIL mid_reset activity after release got %0d cycles want 0", en_cnt);
        end
        a_start = 1'b1;
        expect_burst(0, "after_reset", 1'b0);
    endtask

    task automatic test_start_through_reset();
        for (int k = 0; k < NUM; k++) mat[k] = int'($urandom_range(0, 65535));
        a_c = pack_mat();
        build_expect(0, 16);
        a_start = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expect_burst(0, "start_through_reset", 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_held_start();
        test_saturate();
        test_wrap();
        test_mid_reset();
        test_start_through_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
